// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : RV32I load/store unit. Computes the effective address,
//               checks alignment and legality, drives a req/gnt/rvalid data
//               bus, lane-aligns store data, extracts and extends load data,
//               and writes loads back to the register file. A watchdog aborts
//               stalled bus accesses with a fault.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] base_i,
  input  logic [31:0] offset_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  dest_reg_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wr_en_o,
  output logic [4:0]  wr_reg_o,
  output logic [31:0] wr_data_o,
  output logic        done_o,
  output logic        fault_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t      state_q;
  logic [1:0]  ea_lo_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic [4:0]  dest_q;
  logic [7:0]  wd_cnt_q;

  logic [31:0] ea_d;
  logic        bad_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_shift;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        wd_expired;

  // Expiry is flagged during the last allowed REQ/WAIT cycle so that a
  // grant or rvalid arriving in that same cycle still takes priority.
  assign wd_expired = (TIMEOUT_CYCLES != 8'd0) && (wd_cnt_q == TIMEOUT_CYCLES - 8'd1);

  // Address generation, legality/alignment decode and store lane steering
  always_comb begin
    ea_d  = base_i + offset_i;
    bad_d = 1'b0;
    case (funct3_i)
      3'b000:  bad_d = 1'b0;
      3'b001:  bad_d = ea_d[0];
      3'b010:  bad_d = |ea_d[1:0];
      3'b100:  bad_d = is_store_i;
      3'b101:  bad_d = is_store_i | ea_d[0];
      default: bad_d = 1'b1;
    endcase
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << ea_d[1:0];
        wdata_d = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        wstrb_d = 4'b0011 << ea_d[1:0];
        wdata_d = {2{store_data_i[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = store_data_i;
      end
    endcase
  end

  // Load data extraction and sign/zero extension from the latched address
  always_comb begin
    ld_shift = mem_rdata_i >> {ea_lo_q, 3'b000};
    ld_half  = ea_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Access sequencer with registered bus, writeback and status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ea_lo_q     <= 2'd0;
      funct3_q    <= 3'd0;
      is_store_q  <= 1'b0;
      dest_q      <= 5'd0;
      wd_cnt_q    <= 8'd0;
      req_ready_o <= 1'b1;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      mem_wstrb_o <= 4'd0;
      wr_en_o     <= 1'b0;
      wr_reg_o    <= 5'd0;
      wr_data_o   <= 32'd0;
      done_o      <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      done_o  <= 1'b0;
      fault_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            ea_lo_q     <= ea_d[1:0];
            funct3_q    <= funct3_i;
            is_store_q  <= is_store_i;
            dest_q      <= dest_reg_i;
            req_ready_o <= 1'b0;
            if (bad_d) begin
              done_o  <= 1'b1;
              fault_o <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_store_i;
              mem_addr_o  <= {ea_d[31:2], 2'b00};
              mem_wdata_o <= is_store_i ? wdata_d : 32'd0;
              mem_wstrb_o <= is_store_i ? wstrb_d : 4'd0;
              wd_cnt_q    <= 8'd0;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            wd_cnt_q  <= 8'd0;
            if (is_store_q) begin
              done_o  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (wd_expired) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            done_o    <= 1'b1;
            fault_o   <= 1'b1;
            state_q   <= S_FAULT;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            wr_en_o   <= (dest_q != 5'd0);
            wr_reg_o  <= dest_q;
            wr_data_o <= ld_data;
            done_o    <= 1'b1;
            state_q   <= S_WB;
          end else if (wd_expired) begin
            done_o  <= 1'b1;
            fault_o <= 1'b1;
            state_q <= S_FAULT;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
        default: begin
          req_ready_o <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
